tune_sequencer: RTL and testbench
=================================

// Module: tune_sequencer
// PURPOSE
//  Sequences note playback for the tune player. Walks a per-song note table in
//  an external synchronous ROM and times each note in prescaled ticks.
//  Drives pitch index, load strobe and enable to the downstream tone generator.
//  Sits between the io_in controls (play, song select) and the tone/speaker datapath.
// PARAMETERS
//  MAX_COUNT  100    clocks per duration tick (sim uses small values, e.g. 4)
//  PTR_W      5      note-pointer width; max 2^PTR_W entries per song
//  GAP_TICKS  1      silent ticks after every note; 0 = legato, no gap
//  LOOP       1      1 = restart song at end marker; 0 = stop in DONE
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous reset, active-low
//  play       in   1        1 = run, 0 = pause
//  song_sel   in   2        song bank select (db_sel)
//  rom_addr   out  2+PTR_W  {song_sel_q, ptr}
//  rom_data   in   10       {dur[3:0], pitch[5:0]}; valid 1 clk after rom_addr
//  tone_idx   out  6        pitch index to tone generator
//  tone_load  out  1        1-clk strobe: tone_idx is new
//  tone_en    out  1        1 = tone generator sounds
//  busy       out  1        1 in FETCH/WAIT/LOAD/PLAY/GAP
//  done       out  1        1 in DONE
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state IDLE, ptr=0, prescaler=0, tick_cnt=0,
//    song_sel_q=0. All outputs 0; rom_addr=0.
//  - Entry decode: pitch 0 = rest; pitch 6'h3F = END marker; dur+1 = ticks.
//  - FSM: IDLE -play-> FETCH (drive rom_addr) -> WAIT (rom_data valid)
//    -> LOAD -> PLAY -> GAP -> FETCH with ptr+1. END: LOOP ? FETCH with ptr=0
//    : DONE. IDLE with play=0 stays in IDLE.
//  - LOAD (1 clk): latches pitch/dur. Non-rest note: tone_idx=pitch,
//    tone_load=1, tone_en=1 from the next clk. Rest: tone_idx and tone_en stay
//    0, no strobe. Prescaler and tick_cnt are cleared.
//  - FETCH->first PLAY clk latency = 3 clk.
//  - PLAY lasts exactly (dur+1)*MAX_COUNT clk. Prescaler counts
//    0..MAX_COUNT-1; tick fires at MAX_COUNT-1.
//  - GAP lasts exactly GAP_TICKS*MAX_COUNT clk with tone_en=0. GAP_TICKS=0
//    skips GAP.
//  - Pointer wrap: after ptr = 2^PTR_W-1 the table is treated as END.
//  - END reached from IDLE/first entry (empty song): LOOP=1 must not spin hot.
//    Go to DONE regardless of LOOP.
//  - play=0 in any busy state (pause): freeze state, ptr, prescaler and
//    tick_cnt; tone_en=0. A pending tone_load is held. On resume the note
//    continues, so total on-time is unchanged.
//  - song_sel is registered. A change of song_sel_q in any state aborts the
//    current note: tone_en=0 at the next clk, ptr=0, state FETCH (IDLE if
//    play=0). A song change also leaves DONE.
//  - Song change and pause in the same clk: the song change applies and the
//    block stays paused in IDLE.
//  - Reset mid-note: tone_en falls at the reset edge; the reset values above apply.
// STRUCTURE
//  - Shared pkg tune_pkg: FSM state encoding (IDLE, FETCH, WAIT, LOAD, PLAY,
//    GAP, DONE); PITCH_REST=6'h00; PITCH_END=6'h3F; entry field offsets
//    DUR_MSB/LSB and PITCH_MSB/LSB.
//  - One sub-module tick_prescaler #(MAX_COUNT): ports clk, rst, en, clr,
//    output tick. Reused by the tone path.
//  - The rest (FSM, ptr, tick_cnt) is in this module.
// TESTING
//  (MAX_COUNT=4, GAP_TICKS=1 unless stated)
//  1 Reset: hold rst=0 for 3 clk with play=1 -> all outputs 0, rom_addr=0.
//    Release -> FETCH 1 clk later.
//  2 Song 0 = {dur=2,pitch=5},END with LOOP=0 -> one tone_load with tone_idx=5.
//    Then tone_en=1 for exactly 12 clk, 0 for 4 clk, then done=1 and busy=0.
//  3 Rest entry {dur=0,pitch=0} -> no tone_load; tone_en=0 for 4+4 clk;
//    ptr advances to 1.
//  4 song_sel 0->2 at clk 5 of a note -> tone_en=0 within 2 clk;
//    next rom_addr={2'b10,0}.
//  5 play=0 for 10 clk mid-note -> tone_en=0 while paused, state held.
//    Summed tone_en high time = 12 clk.
//  6 PTR_W=2, table without END, LOOP=1 -> after entry 3, rom_addr wraps to
//    {sel,0}; DONE is never asserted.

Source files
------------

// File: rtl/tune_pkg.sv
// Shared definitions for the tune player sequencer.
// Contents:
//   state_t        sequencer FSM state encoding
//   PITCH_REST     pitch code for a silent (rest) entry
//   PITCH_END      pitch code marking the end of a song table
//   DUR_*/PITCH_*  bit positions of the fields inside a 10-bit note entry
//   state_is_busy  1 for the states in which a note is being fetched/played
package tune_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_PLAY  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [5:0] PITCH_REST = 6'h00;
    localparam logic [5:0] PITCH_END  = 6'h3F;

    localparam int DUR_MSB   = 9;
    localparam int DUR_LSB   = 6;
    localparam int PITCH_MSB = 5;
    localparam int PITCH_LSB = 0;

    function automatic logic state_is_busy(input state_t st);
        logic busy_v;
        case (st)
            ST_FETCH, ST_WAIT, ST_LOAD, ST_PLAY, ST_GAP: busy_v = 1'b1;
            default:                                    busy_v = 1'b0;
        endcase
        return busy_v;
    endfunction

endpackage

// File: rtl/tune_sequencer_tick_prescaler.sv
// tick_prescaler: divides the system clock into duration ticks.
// The counter runs 0..MAX_COUNT-1 while en is high and freezes while en is
// low; tick is a one-clock pulse on the last count of each period.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-low
//   en    in   count enable (low = hold)
//   clr   in   restart the period from zero (wins over en)
//   tick  out  period complete this clock
module tick_prescaler #(
    parameter int MAX_COUNT = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: clear, wrap at LAST, or hold when disabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/tune_sequencer.sv
// tune_sequencer: walks a per-song note table in an external synchronous ROM
// and times each note in prescaled ticks, driving the tone generator.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   play       in   1 = run, 0 = pause
//   song_sel   in   song bank select (registered internally)
//   rom_addr   out  {song_sel_q, ptr}
//   rom_data   in   {dur[3:0], pitch[5:0]}, valid one clock after rom_addr
//   tone_idx   out  pitch index for the tone generator
//   tone_load  out  one-clock strobe: tone_idx is new
//   tone_en    out  tone generator sounds
//   busy       out  fetching or playing a note
//   done       out  song finished (non-looping or empty song)
module tune_sequencer #(
    parameter int MAX_COUNT = 100,
    parameter int PTR_W     = 5,
    parameter int GAP_TICKS = 1,
    parameter int LOOP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             play,
    input  logic [1:0]       song_sel,
    output logic [PTR_W+1:0] rom_addr,
    input  logic [9:0]       rom_data,
    output logic [5:0]       tone_idx,
    output logic             tone_load,
    output logic             tone_en,
    output logic             busy,
    output logic             done
);

    import tune_pkg::*;

    localparam bit LOOP_EN = (LOOP != 0);
    localparam bit HAS_GAP = (GAP_TICKS > 0);
    // tick counter must hold both a 4-bit duration and the gap length
    localparam int TCW = ($clog2(GAP_TICKS + 1) > 4) ? $clog2(GAP_TICKS + 1) : 4;
    localparam logic [TCW-1:0] GAP_LAST = HAS_GAP ? TCW'(GAP_TICKS - 1) : '0;

    state_t           state_q,    state_d;
    logic [PTR_W-1:0] ptr_q,      ptr_d;
    logic [1:0]       song_sel_q;
    logic [TCW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]       dur_q,      dur_d;
    logic             note_on_q,  note_on_d;
    logic [5:0]       tone_idx_q, tone_idx_d;
    logic             tone_load_q, tone_load_d;
    logic             tone_en_q,  tone_en_d;
    logic             busy_q;
    logic             done_q;

    logic             sel_chg_s;
    logic             pre_en_s;
    logic             pre_clr_s;
    logic             tick_s;
    logic             last_s;
    logic [PTR_W-1:0] ptr_next_s;
    state_t           state_next_s;
    logic [3:0]       rom_dur_s;
    logic [5:0]       rom_pitch_s;

    assign rom_dur_s   = rom_data[DUR_MSB:DUR_LSB];
    assign rom_pitch_s = rom_data[PITCH_MSB:PITCH_LSB];

    // song_sel differs from its registered copy: song_sel_q changes this edge
    assign sel_chg_s = (song_sel != song_sel_q);

    // the prescaler only runs while a note or gap is timing and not paused
    assign pre_en_s = play && !sel_chg_s && ((state_q == ST_PLAY) || (state_q == ST_GAP));

    // after the last table slot the song ends as if an END marker was read
    assign last_s       = (ptr_q == {PTR_W{1'b1}});
    assign ptr_next_s   = last_s ? '0 : (ptr_q + PTR_W'(1));
    assign state_next_s = (last_s && !LOOP_EN) ? ST_DONE : ST_FETCH;

    tick_prescaler #(
        .MAX_COUNT (MAX_COUNT)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en_s),
        .clr  (pre_clr_s),
        .tick (tick_s)
    );

    // next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        tick_cnt_d  = tick_cnt_q;
        dur_d       = dur_q;
        note_on_d   = note_on_q;
        tone_idx_d  = tone_idx_q;
        tone_load_d = 1'b0;
        tone_en_d   = 1'b0;
        pre_clr_s   = 1'b0;
        if (sel_chg_s) begin
            // song change aborts everything, even from DONE
            ptr_d      = '0;
            tick_cnt_d = '0;
            pre_clr_s  = 1'b1;
            if (play) begin
                state_d = ST_FETCH;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (!play) begin
            // paused (or idle): everything holds, tone silenced by default
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (rom_pitch_s == PITCH_END) begin
                        // an END in slot 0 is an empty song: never loop on it
                        if (LOOP_EN && (ptr_q != '0)) begin
                            state_d = ST_FETCH;
                            ptr_d   = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // address is unchanged since FETCH, so rom_data is still valid
                    dur_d       = rom_dur_s;
                    note_on_d   = (rom_pitch_s != PITCH_REST);
                    tone_idx_d  = rom_pitch_s;
                    tone_load_d = (rom_pitch_s != PITCH_REST);
                    tone_en_d   = (rom_pitch_s != PITCH_REST);
                    tick_cnt_d  = '0;
                    pre_clr_s   = 1'b1;
                    state_d     = ST_PLAY;
                end
                ST_PLAY: begin
                    if (tick_s && (tick_cnt_q == TCW'(dur_q))) begin
                        tick_cnt_d = '0;
                        if (HAS_GAP) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = state_next_s;
                            ptr_d   = ptr_next_s;
                        end
                    end else if (tick_s) begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                        tone_en_d  = note_on_q;
                    end else begin
                        tone_en_d = note_on_q;
                    end
                end
                ST_GAP: begin
                    if (tick_s && (tick_cnt_q == GAP_LAST)) begin
                        tick_cnt_d = '0;
                        state_d    = state_next_s;
                        ptr_d      = ptr_next_s;
                    end else if (tick_s) begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end else begin
                        tick_cnt_d = tick_cnt_q;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // state, pointer, note fields and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            song_sel_q  <= 2'b00;
            tick_cnt_q  <= '0;
            dur_q       <= 4'd0;
            note_on_q   <= 1'b0;
            tone_idx_q  <= 6'd0;
            tone_load_q <= 1'b0;
            tone_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            song_sel_q  <= song_sel;
            tick_cnt_q  <= tick_cnt_d;
            dur_q       <= dur_d;
            note_on_q   <= note_on_d;
            tone_idx_q  <= tone_idx_d;
            tone_load_q <= tone_load_d;
            tone_en_q   <= tone_en_d;
            busy_q      <= state_is_busy(state_d);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign rom_addr  = {song_sel_q, ptr_q};
    assign tone_idx  = tone_idx_q;
    assign tone_load = tone_load_q;
    assign tone_en   = tone_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Bench for tune_sequencer. Instance A: MAX_COUNT=4, PTR_W=5, GAP_TICKS=1,
// LOOP=0. Instance B: MAX_COUNT=4, PTR_W=2, GAP_TICKS=1, LOOP=1.
// Each instance reads a small behavioural synchronous ROM.
module tb_tune_sequencer;

    logic       clk;
    logic       rst;
    logic       play_a, play_b;
    logic [1:0] song_sel_a, song_sel_b;
    logic [6:0] rom_addr_a;
    logic [3:0] rom_addr_b;
    logic [9:0] rom_data_a, rom_data_b;
    logic [5:0] tone_idx_a, tone_idx_b;
    logic       tone_load_a, tone_load_b;
    logic       tone_en_a, tone_en_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    logic [9:0] mem_a [128];
    logic [9:0] mem_b [16];

    tune_sequencer #(.MAX_COUNT(4), .PTR_W(5), .GAP_TICKS(1), .LOOP(0)) dut_a (
        .clk(clk), .rst(rst), .play(play_a), .song_sel(song_sel_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .tone_idx(tone_idx_a),
        .tone_load(tone_load_a), .tone_en(tone_en_a), .busy(busy_a), .done(done_a)
    );

    tune_sequencer #(.MAX_COUNT(4), .PTR_W(2), .GAP_TICKS(1), .LOOP(1)) dut_b (
        .clk(clk), .rst(rst), .play(play_b), .song_sel(song_sel_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .tone_idx(tone_idx_b),
        .tone_load(tone_load_b), .tone_en(tone_en_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous ROMs: data one clock after address
    always @(posedge clk) begin
        rom_data_a <= mem_a[rom_addr_a];
        rom_data_b <= mem_b[rom_addr_b];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // scoreboard of expected tone_idx values for instance A
    logic [5:0] exp_q [$];
    logic [5:0] exp_v;

    always @(negedge clk) begin
        if (tone_load_a === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_load: got tone_idx %0d, expected no strobe", tone_idx_a);
            end else begin
                exp_v = exp_q.pop_front();
                check("sb_tone_idx", {26'd0, tone_idx_a}, {26'd0, exp_v});
            end
        end
    end

    typedef struct {
        logic [3:0] dur;
        logic [5:0] pitch;
        int         exp_on;
        int         exp_loads;
        int         exp_maxptr;
        int         exp_tail;
    } vec_t;

    vec_t vecs [5];

    int on_cnt, load_cnt, max_ptr, tail_cnt, samp_idx, first_load;
    bit fin;

    task automatic clear_cnt();
        on_cnt = 0; load_cnt = 0; max_ptr = 0; tail_cnt = 0;
        samp_idx = 0; first_load = -1; fin = 1'b0;
    endtask

    task automatic sample_a();
        @(negedge clk);
        if (done_a === 1'b1) begin
            fin = 1'b1;
        end else begin
            samp_idx++;
            if (tone_en_a === 1'b1) begin
                on_cnt++;
                tail_cnt = 0;
            end else begin
                tail_cnt++;
            end
            if (tone_load_a === 1'b1) begin
                load_cnt++;
                if (first_load < 0) first_load = samp_idx;
            end
            if (int'(rom_addr_a[4:0]) > max_ptr) max_ptr = int'(rom_addr_a[4:0]);
        end
    endtask

    task automatic run_to_done(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (!fin) sample_a();
        end
        check(name, {31'd0, fin}, 32'd1);
    endtask

    task automatic load_a_song0(input logic [3:0] dur, input logic [5:0] pitch);
        for (int i = 0; i < 128; i++) mem_a[i] = 10'h03F;
        mem_a[0] = {dur, pitch};
        mem_a[1] = 10'h03F;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; play_a = 1'b1; play_b = 1'b0;
        song_sel_a = 2'b00; song_sel_b = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    int hi_pause, on_before, wraps, loads_b, prev_ptr;
    bit held, done_seen;
    logic [6:0] addr_hold;

    initial begin
        vecs[0] = '{4'd2,  6'd5,  12, 1, 1, 6};
        vecs[1] = '{4'd0,  6'd0,  0,  0, 1, 13};
        vecs[2] = '{4'd0,  6'h3F, 0,  0, 0, 2};
        vecs[3] = '{4'd15, 6'd33, 64, 1, 1, 6};
        vecs[4] = '{4'd3,  6'd1,  16, 1, 1, 6};

        rst = 1'b0; play_a = 1'b1; play_b = 1'b0;
        song_sel_a = 2'b00; song_sel_b = 2'b00;
        for (int i = 0; i < 16; i++) mem_b[i] = 10'h03F;
        load_a_song0(4'd2, 6'd5);

        // reset held with play=1: everything zero, then FETCH one clock after release
        repeat (3) begin
            @(negedge clk);
            check("rst_outputs", {15'd0, rom_addr_a, tone_idx_a, tone_load_a, tone_en_a, busy_a, done_a}, 32'd0);
        end
        exp_q.push_back(6'd5);
        clear_cnt();
        rst = 1'b1;
        sample_a();
        check("fetch_after_rst_busy", {31'd0, busy_a}, 32'd1);
        check("fetch_after_rst_addr", {25'd0, rom_addr_a}, 32'd0);
        run_to_done("first_done", 200);
        check("first_load_latency", first_load, 32'd4);
        check("first_on_clk", on_cnt, 32'd12);
        check("first_busy_in_done", {31'd0, busy_a}, 32'd0);

        // table of single-entry songs
        for (int i = 0; i < 5; i++) begin
            do_reset();
            load_a_song0(vecs[i].dur, vecs[i].pitch);
            if (vecs[i].exp_loads == 1) exp_q.push_back(vecs[i].pitch);
            clear_cnt();
            rst = 1'b1;
            run_to_done("vec_done", 300);
            check("vec_on_clk", on_cnt, vecs[i].exp_on);
            check("vec_loads", load_cnt, vecs[i].exp_loads);
            check("vec_max_ptr", max_ptr, vecs[i].exp_maxptr);
            check("vec_tail", tail_cnt, vecs[i].exp_tail);
            check("vec_busy_done", {30'd0, busy_a, done_a}, 32'd1);
        end

        // song change mid-note
        do_reset();
        load_a_song0(4'd2, 6'd5);
        mem_a[64] = {4'd1, 6'd7};
        mem_a[65] = 10'h03F;
        exp_q.push_back(6'd5);
        clear_cnt();
        rst = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (on_cnt < 5) sample_a();
        end
        check("sel_reach_on5", on_cnt, 32'd5);
        song_sel_a = 2'b10;
        exp_q.push_back(6'd7);
        sample_a();
        check("sel_tone_off", {31'd0, tone_en_a}, 32'd0);
        check("sel_rom_addr", {25'd0, rom_addr_a}, 32'h40);
        on_before = on_cnt;
        run_to_done("sel_done", 200);
        check("sel_new_on_clk", on_cnt - on_before, 32'd8);
        song_sel_a = 2'b00;
        @(negedge clk);
        check("sel_leaves_done", {30'd0, busy_a, done_a}, 32'd2);

        // pause for 10 clocks mid-note
        do_reset();
        load_a_song0(4'd2, 6'd5);
        exp_q.push_back(6'd5);
        clear_cnt();
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (on_cnt < 4) sample_a();
        end
        check("pause_reach_on4", on_cnt, 32'd4);
        play_a = 1'b0;
        hi_pause = 0; held = 1'b1;
        @(negedge clk);
        addr_hold = rom_addr_a;
        if (tone_en_a !== 1'b0) hi_pause++;
        repeat (9) begin
            @(negedge clk);
            if (tone_en_a !== 1'b0) hi_pause++;
            if (busy_a !== 1'b1 || rom_addr_a !== addr_hold || tone_load_a !== 1'b0) held = 1'b0;
        end
        check("pause_tone_high", hi_pause, 32'd0);
        check("pause_held", {31'd0, held}, 32'd1);
        play_a = 1'b1;
        run_to_done("pause_done", 200);
        check("pause_total_on", on_cnt, 32'd12);

        // instance B: 4-slot table without END, looping
        do_reset();
        for (int i = 0; i < 4; i++) mem_b[i] = {4'd0, 6'd9};
        play_a = 1'b0;
        play_b = 1'b1;
        rst = 1'b1;
        wraps = 0; loads_b = 0; prev_ptr = 0; done_seen = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (prev_ptr == 3 && rom_addr_b[1:0] == 2'd0) wraps++;
            prev_ptr = int'(rom_addr_b[1:0]);
            if (done_b !== 1'b0) done_seen = 1'b1;
            if (tone_load_b === 1'b1) begin
                loads_b++;
                check("wrap_tone_idx", {26'd0, tone_idx_b}, 32'd9);
            end
        end
        check("wrap_count", wraps, 32'd2);
        check("wrap_loads", loads_b, 32'd11);
        check("wrap_no_done", {31'd0, done_seen}, 32'd0);

        // empty song with LOOP=1 ends in DONE
        song_sel_b = 2'b01;
        for (int c = 0; c < 6; c++) begin
            if (done_b !== 1'b1) @(negedge clk);
        end
        check("empty_loop_done", {31'd0, done_b}, 32'd1);
        check("empty_loop_addr", {28'd0, rom_addr_b}, 32'h4);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
